// File: rtl/axil_sir_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_sir_bridge
// Purpose  : AXI4-Lite slave to Sir register-bus master, one access at a time.
//            Optional macro SIR_BRIDGE_TIMEOUT_EN adds an SLVERR ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axil_sir_bridge #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRWIDTH+1:0]   s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DATAWIDTH-1:0]   s_wdata,
  input  logic [DATAWIDTH/8-1:0] s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDRWIDTH+1:0]   s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DATAWIDTH-1:0]   s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic                   SirSel,
  output logic                   SirRead,
  output logic [ADDRWIDTH-1:0]   SirAddr,
  output logic [DATAWIDTH-1:0]   SirWdat,
  input  logic                   SirDack,
  input  logic [DATAWIDTH-1:0]   SirRdat
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SEL    = 2'd1;
  localparam logic [1:0] c_BRESP  = 2'd2;
  localparam logic [1:0] c_RRESP  = 2'd3;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;

  logic [1:0]           r_state;
  logic [1:0]           w_nextState;
  logic                 r_lastWrite;
  logic                 r_read;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_wdat;
  logic [DATAWIDTH-1:0] r_rdata;
  logic [1:0]           r_resp;
  logic                 w_wrElig;
  logic                 w_rdElig;
  logic                 w_takeWr;
  logic                 w_takeRd;
  logic                 w_timeout;
  logic                 w_done;

  // Byte-lane bits and strobes carry no information on a word-wide bus.
  logic w_unused;
  assign w_unused = &{1'b0, s_wstrb, s_awaddr[1:0], s_araddr[1:0]};

  assign w_wrElig = s_awvalid & s_wvalid;
  assign w_rdElig = s_arvalid;
  // On contention the type not served last wins; after reset that is the write.
  assign w_takeWr = (r_state == c_IDLE) & ~rst & w_wrElig & (~w_rdElig | ~r_lastWrite);
  assign w_takeRd = (r_state == c_IDLE) & ~rst & w_rdElig & ~w_takeWr;

`ifdef SIR_BRIDGE_TIMEOUT_EN
  localparam int                  c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0]  c_CNTLAST = c_CNT_W'(TIMEOUT - 1);
  logic [c_CNT_W-1:0] r_cnt;

  // r_cnt holds the number of SEL cycles already elapsed, so the TIMEOUT-th cycle is the last.
  always_ff @(posedge clk) begin
    if (rst || r_state != c_SEL) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == c_SEL) & ~SirDack & (r_cnt == c_CNTLAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == c_SEL) & (SirDack | w_timeout);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (w_takeWr || w_takeRd) w_nextState = c_SEL;
      c_SEL:   if (w_done) w_nextState = r_read ? c_RRESP : c_BRESP;
      c_BRESP: if (s_bready) w_nextState = c_IDLE;
      c_RRESP: if (s_rready) w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastWrite <= 1'b0;
      r_read      <= 1'b0;
      r_addr      <= '0;
      r_wdat      <= '0;
      r_rdata     <= '0;
      r_resp      <= c_OKAY;
    end else begin
      if (w_takeWr) begin
        r_addr      <= s_awaddr[ADDRWIDTH+1:2];
        r_wdat      <= s_wdata;
        r_read      <= 1'b0;
        r_lastWrite <= 1'b1;
      end else if (w_takeRd) begin
        r_addr      <= s_araddr[ADDRWIDTH+1:2];
        r_wdat      <= '0;
        r_read      <= 1'b1;
        r_lastWrite <= 1'b0;
      end
      if (w_done) begin
        r_resp  <= w_timeout ? c_SLVERR : c_OKAY;
        r_rdata <= (r_read && !w_timeout) ? SirRdat : '0;
      end
    end
  end

  always_comb begin
    s_awready = w_takeWr;
    s_wready  = w_takeWr;
    s_arready = w_takeRd;
    SirSel    = (r_state == c_SEL);
    SirRead   = (r_state == c_SEL) & r_read;
    SirAddr   = (r_state == c_SEL) ? r_addr : '0;
    SirWdat   = (r_state == c_SEL) ? r_wdat : '0;
    s_bvalid  = (r_state == c_BRESP);
    s_bresp   = (r_state == c_BRESP) ? r_resp : c_OKAY;
    s_rvalid  = (r_state == c_RRESP);
    s_rresp   = (r_state == c_RRESP) ? r_resp : c_OKAY;
    s_rdata   = (r_state == c_RRESP) ? r_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_sir_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_sir_bridge
// Purpose  : Scoreboard bench for axil_sir_bridge with two modelled Sir slaves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_sir_bridge;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_wstrb = 4'hF;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b1;
  logic [AW+1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b1;
  logic          SirSel;
  logic          SirRead;
  logic [AW-1:0] SirAddr;
  logic [DW-1:0] SirWdat;
  logic          SirDack;
  logic [DW-1:0] SirRdat;

  always #5 clk = ~clk;

  axil_sir_bridge #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .SirSel(SirSel), .SirRead(SirRead), .SirAddr(SirAddr), .SirWdat(SirWdat),
    .SirDack(SirDack), .SirRdat(SirRdat)
  );

  // Registered Sir slaves at word addresses 1 and 2; every other address is unmapped.
  logic [DW-1:0] q1 = '0, q2 = '0, slvRdat = '0;
  logic          slvDack = 1'b0;
  always @(posedge clk) begin
    if (SirSel && !slvDack && (SirAddr == 8'd1 || SirAddr == 8'd2)) begin
      slvDack <= 1'b1;
      if (!SirRead) begin
        if (SirAddr == 8'd1) q1 <= SirWdat; else q2 <= SirWdat;
        slvRdat <= '0;
      end else begin
        slvRdat <= (SirAddr == 8'd1) ? q1 : q2;
      end
    end else begin
      slvDack <= 1'b0;
      slvRdat <= '0;
    end
  end
  assign SirDack = slvDack;
  assign SirRdat = slvRdat;

  typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdat; int len; } sirExp_t;
  typedef struct { logic [1:0] resp; logic [DW-1:0] data; int lat; } rspExp_t;
  sirExp_t sirQ[$];
  rspExp_t bQ[$];
  rspExp_t rQ[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expWrite(input logic [AW+1:0] a, input logic [DW-1:0] d);
    sirQ.push_back('{1'b0, a[AW+1:2], d, 2});
    bQ.push_back('{2'b00, 32'h0, 3});
  endtask

  task automatic expRead(input logic [AW+1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] resp, input int len, input int lat);
    sirQ.push_back('{1'b1, a[AW+1:2], 32'h0, len});
    rQ.push_back('{resp, d, lat});
  endtask

  task automatic axiWrite(input logic [AW+1:0] a, input logic [DW-1:0] d);
    int n = 0;
    s_awaddr = a; s_wdata = d; s_awvalid = 1'b1; s_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!(s_awready && s_wready) && n < 60);
    check("write accepted", {63'd0, s_awready & s_wready}, 64'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic axiRead(input logic [AW+1:0] a);
    int n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_arready && n < 60);
    check("read accepted", {63'd0, s_arready}, 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sirQ.size() + bQ.size() + rQ.size()) != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    check("drain completes", {63'd0, n < 200}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " SirSel"},    {63'd0, SirSel},    64'd0);
    check({tag, " SirRead"},   {63'd0, SirRead},   64'd0);
    check({tag, " SirAddr"},   64'(SirAddr),       64'd0);
    check({tag, " SirWdat"},   64'(SirWdat),       64'd0);
    check({tag, " awready"},   {63'd0, s_awready}, 64'd0);
    check({tag, " wready"},    {63'd0, s_wready},  64'd0);
    check({tag, " arready"},   {63'd0, s_arready}, 64'd0);
    check({tag, " bvalid"},    {63'd0, s_bvalid},  64'd0);
    check({tag, " bresp"},     64'(s_bresp),       64'd0);
    check({tag, " rvalid"},    {63'd0, s_rvalid},  64'd0);
    check({tag, " rresp"},     64'(s_rresp),       64'd0);
    check({tag, " rdata"},     64'(s_rdata),       64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a Sir access or AXI response.
  int      cyc = 0;
  int      acceptCyc = 0, selLen = 0, gapLen = 0;
  logic    prevSel = 1'b0, prevB = 1'b0, prevR = 1'b0, haveGap = 1'b0;
  logic [1:0]    heldB = '0, heldR = '0;
  logic [DW-1:0] heldRd = '0;
  sirExp_t curSir;
  rspExp_t e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prevSel = 1'b0; prevB = 1'b0; prevR = 1'b0; haveGap = 1'b0; selLen = 0; gapLen = 0;
    end else begin
      if ((s_awready && s_awvalid && s_wvalid) || (s_arready && s_arvalid)) acceptCyc = cyc;
      if (SirSel) begin
        if (!prevSel) begin
          if (haveGap) check("SirSel low gap >= 2", {63'd0, gapLen >= 2}, 64'd1);
          if (sirQ.size() == 0) begin
            check("unexpected SirSel", 64'd1, 64'd0);
            curSir = '{1'b0, '0, '0, 0};
          end else curSir = sirQ.pop_front();
          selLen = 0;
        end
        check("Sir read/addr/wdat", 64'({SirRead, SirAddr, SirWdat}),
              64'({curSir.rd, curSir.addr, curSir.wdat}));
        selLen++;
      end else begin
        if (prevSel) begin
          check("SirSel high cycles", 64'(selLen), 64'(curSir.len));
          haveGap = 1'b1; gapLen = 0;
        end
        gapLen++;
        check("Sir idle outputs zero", 64'({SirRead, SirAddr, SirWdat}), 64'd0);
      end
      prevSel = SirSel;

      if (s_bvalid) begin
        if (!prevB) begin
          if (bQ.size() == 0) check("unexpected bvalid", 64'd1, 64'd0);
          else check("bvalid latency", 64'(cyc - acceptCyc), 64'(bQ[0].lat));
          heldB = s_bresp;
        end else check("bresp stable", 64'(s_bresp), 64'(heldB));
        check("no accept during bvalid", 64'({s_awready, s_wready, s_arready}), 64'd0);
        if (s_bready && bQ.size() != 0) begin
          e = bQ.pop_front();
          check("bresp", 64'(s_bresp), 64'(e.resp));
        end
      end
      prevB = s_bvalid;

      if (s_rvalid) begin
        if (!prevR) begin
          if (rQ.size() == 0) check("unexpected rvalid", 64'd1, 64'd0);
          else check("rvalid latency", 64'(cyc - acceptCyc), 64'(rQ[0].lat));
          heldR = s_rresp; heldRd = s_rdata;
        end else check("rdata/rresp stable", 64'({s_rresp, s_rdata}), 64'({heldR, heldRd}));
        check("no accept during rvalid", 64'({s_awready, s_wready, s_arready}), 64'd0);
        if (s_rready && rQ.size() != 0) begin
          e = rQ.pop_front();
          check("rdata", 64'(s_rdata), 64'(e.data));
          check("rresp", 64'(s_rresp), 64'(e.resp));
        end
      end
      prevR = s_rvalid;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous AW/W/AR straight after reset: write first, then read.
    expWrite(10'h004, 32'h0000_00A5);
    expRead(10'h004, 32'h0000_00A5, 2'b00, 2, 3);
    fork
      axiWrite(10'h004, 32'h0000_00A5);
      axiRead(10'h004);
    join
    drain();
    check("slave q1", 64'(q1), 64'h0000_00A5);

    expWrite(10'h008, 32'hDEAD_BEEF); axiWrite(10'h008, 32'hDEAD_BEEF); drain();
    expRead(10'h008, 32'hDEAD_BEEF, 2'b00, 2, 3); axiRead(10'h008); drain();
    check("slave q2", 64'(q2), 64'hDEAD_BEEF);

    // Write served last, so on contention the read goes first.
    expWrite(10'h008, 32'h1234_5678); axiWrite(10'h008, 32'h1234_5678); drain();
    expRead(10'h008, 32'h1234_5678, 2'b00, 2, 3);
    expWrite(10'h004, 32'h0000_005A);
    fork
      axiWrite(10'h004, 32'h0000_005A);
      axiRead(10'h008);
    join
    drain();
    check("slave q1 after contention", 64'(q1), 64'h0000_005A);

    // Back-pressure on B with a read pending behind it.
    s_bready = 1'b0;
    expWrite(10'h004, 32'h0000_0077);
    expRead(10'h004, 32'h0000_0077, 2'b00, 2, 3);
    axiWrite(10'h004, 32'h0000_0077);
    fork
      begin repeat (12) @(posedge clk); #1; s_bready = 1'b1; end
      axiRead(10'h004);
    join
    drain();

    // Reset in cycle 1 of a write drops the access and its response.
    axiWrite(10'h008, 32'hCAFE_F00D);
    check("SirSel before mid reset", {63'd0, SirSel}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("SirSel after mid reset", {63'd0, SirSel}, 64'd0);
    check("bvalid after mid reset", {63'd0, s_bvalid}, 64'd0);
    repeat (4) @(posedge clk); #1;
    check("bvalid stays low", {63'd0, s_bvalid}, 64'd0);
    expWrite(10'h008, 32'h0BAD_CAFE); axiWrite(10'h008, 32'h0BAD_CAFE); drain();
    expRead(10'h008, 32'h0BAD_CAFE, 2'b00, 2, 3); axiRead(10'h008); drain();

`ifdef SIR_BRIDGE_TIMEOUT_EN
    expRead(10'h3FC, 32'h0, 2'b10, 8, 9);
    axiRead(10'h3FC);
    drain();
`endif

    check("scoreboard empty", 64'(sirQ.size() + bQ.size() + rQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_sir_bridge.md
# axil_sir_bridge

AXI4-Lite slave to Sir register-bus master bridge. Converts processor AXI4-Lite register accesses into single Sir bus transactions (SirSel/SirRead/SirAddr/SirWdat out, SirDack/SirRdat in) and returns the result as an AXI response. It sits directly upstream of the per-register Sir slaves. Their SirDack and SirRdat outputs are OR-reduced externally before they reach this block.

## Interface
Parameters:
- ADDRWIDTH, 8: Sir word-address width. The AXI address width is ADDRWIDTH+2.
- DATAWIDTH, 32: Sir and AXI data width.
- TIMEOUT, 255: maximum number of cycles SirSel stays high while waiting for SirDack. Used only with SIR_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_awaddr  in  ADDRWIDTH+2  write byte address.
- s_awvalid  in  1; s_awready  out  1
- s_wdata  in  DATAWIDTH; s_wstrb  in  DATAWIDTH/8 (ignored); s_wvalid  in  1; s_wready  out  1
- s_bresp  out  2; s_bvalid  out  1; s_bready  in  1
- s_araddr  in  ADDRWIDTH+2; s_arvalid  in  1; s_arready  out  1
- s_rdata  out  DATAWIDTH; s_rresp  out  2; s_rvalid  out  1; s_rready  in  1
- SirSel  out  1  access strobe, held until acknowledged.
- SirRead  out  1  1 = read, 0 = write.
- SirAddr  out  ADDRWIDTH  word address, equal to the AXI address bits [ADDRWIDTH+1:2].
- SirWdat  out  DATAWIDTH  write data.
- SirDack  in  1  OR of all slave acknowledges.
- SirRdat  in  DATAWIDTH  OR of all slave read data. Non-selected slaves drive 0.

## Operation
- The FSM has four states: IDLE, SEL, BRESP, RRESP. Only one transaction is outstanding at a time.
- In IDLE:
  - A write is eligible when s_awvalid and s_wvalid are both high.
  - A read is eligible when s_arvalid is high.
  - When both are eligible, the type not served last wins. After reset the write wins.
- Accepting a write: s_awready and s_wready pulse high together for one cycle. SirAddr and SirWdat are latched, and SirRead=0.
- Accepting a read: s_arready pulses high for one cycle. SirAddr is latched, SirRead=1, and SirWdat=0.
- SEL:
  - SirSel=1, with SirAddr, SirWdat and SirRead held stable.
  - On the first cycle with SirDack=1, SirRdat is captured into s_rdata (reads only) and the FSM moves to BRESP or RRESP. SirSel drops on that same edge.
- BRESP: s_bvalid=1 and s_bresp is held until s_bready=1, then the FSM returns to IDLE.
- RRESP: s_rvalid=1 with s_rdata and s_rresp held until s_rready=1, then the FSM returns to IDLE.
- Whenever SirSel=0, SirRead, SirAddr and SirWdat are driven to 0.
- wstrb is ignored. Every write is a full word.
- An unmapped address with no SirDack hangs the access unless the timeout is compiled in (see Configuration).

## Timing
- All outputs are 0 in reset and after rst, including s_bresp, s_rresp, s_rdata and the ready signals.
- Write path, counting the accept edge as cycle 0:
  - SirSel=1 in cycle 1.
  - A slave raises SirDack in cycle 2.
  - SirSel=0 and s_bvalid=1 in cycle 3.
- Read path: s_rdata equals SirRdat as sampled in the SirDack cycle, and s_rvalid=1 in cycle 3.
- The BRESP/RRESP cycle plus the IDLE accept cycle guarantee at least 2 cycles of SirSel=0 between accesses. Slaves rely on this gap to re-arm their single-write edge detect.
- SirDack in any state other than SEL is ignored.
- rst asserted mid-transaction: the FSM returns to IDLE on the next edge, SirSel drops, and the pending AXI response is discarded.
- s_awvalid without s_wvalid, or the reverse, is not accepted. The bridge waits until both are high.

## Configuration
- Macro SIR_BRIDGE_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to SEL and increments each SEL cycle.
  - If the counter reaches TIMEOUT with SirDack=0, SirSel drops and the FSM responds with resp 2'b10 (SLVERR). For reads, s_rdata=0.
  - If SirDack=1 arrives in the same cycle the counter reaches TIMEOUT, SirDack wins and the response is OKAY.
  - resp is 2'b00 otherwise.
- When not defined: no counter is built, SEL waits indefinitely, and resp is always 2'b00.

## Test plan
- Write, address 0x04 with data 0x0000_00A5: SirSel is high for 2 cycles with SirAddr=0x01, SirWdat=0xA5, SirRead=0. s_bvalid is asserted 3 cycles after accept with s_bresp=0. The slave Q becomes 0xA5.
- Read, address 0x04: s_rvalid is asserted in cycle 3 with s_rdata=0x0000_00A5 and s_rresp=0.
- AW, W and AR all valid in the same cycle after reset: the write is served first, then the read. SirSel shows two pulses separated by at least 2 low cycles.
- s_bready held low for 10 cycles: s_bvalid and s_bresp stay stable for those cycles. No new accept occurs until the handshake completes.
- With SIR_BRIDGE_TIMEOUT_EN and TIMEOUT=8, read of unmapped address 0x3FC: SirSel stays high for 8 cycles, then s_rvalid=1 with s_rresp=2'b10 and s_rdata=0.
- rst pulsed in cycle 1 of a write: SirSel=0 and s_bvalid=0 next cycle. The next write completes normally.
